// File: rtl/sram_confreg_resp.sv
// rtl/sram_confreg_resp.sv - data-SRAM responder: word RAM plus memory-mapped config registers
//
// Answers the core's data-SRAM requests with a fixed one-cycle read latency.
// Addresses with addr[31:16] == CONF_BASE_HI hit the config-register file;
// every other address hits RAM word addr[RAM_AW+1:2], with the upper bits aliased.
// Writes are byte-merged per wen. Every request loads rdata with the word's
// pre-write contents.
//
// Optional feature macro: CONFREG_TIMER_EN (free-running TIMER register at
// offset 16'he000). When the macro is undefined, that offset behaves as unmapped.
//
// Ports:
//   clk             in   1   clock
//   resetn          in   1   asynchronous active-low reset
//   data_sram_en    in   1   request valid this cycle
//   data_sram_wen   in   4   byte write enables, 4'b0000 = read
//   data_sram_addr  in   32  byte address, addr[1:0] ignored
//   data_sram_wdata in   32  write data
//   data_sram_rdata out  32  read data, one cycle after the request
//   led             out  16  LED register
//   num_data        out  32  numeric-display register
//   switch          in   8   raw asynchronous switch inputs

module sram_confreg_resp #(
    parameter int          RAM_AW       = 10,
    parameter logic [15:0] CONF_BASE_HI = 16'hbfaf
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic [31:0] num_data,
    input  logic [7:0]  switch
);

    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_NUM    = 16'hf010;
    localparam logic [15:0] OFF_SWITCH = 16'hf020;
    localparam logic [15:0] OFF_TIMER  = 16'he000;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    // Word RAM, intentionally not reset.
    logic [31:0] ram_mem [2**RAM_AW];

    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [7:0]  sw_sync1_q, sw_sync1_d;
    logic [7:0]  sw_sync2_q, sw_sync2_d;
`ifdef CONFREG_TIMER_EN
    logic [31:0] timer_q, timer_d;
`endif

    logic              is_conf;
    logic              is_write;
    logic [15:0]       conf_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic [31:0]       conf_rdata;
    logic [31:0]       ram_rdata;
    logic              unused_addr_lsb;

    assign is_conf   = (data_sram_addr[31:16] == CONF_BASE_HI);
    assign conf_off  = data_sram_addr[15:0];
    assign ram_idx   = data_sram_addr[RAM_AW+1:2];
    assign is_write  = data_sram_en && (data_sram_wen != 4'b0000);
    assign ram_we    = is_write && !is_conf;
    assign ram_rdata = ram_mem[ram_idx];
    assign unused_addr_lsb = ^data_sram_addr[1:0];

    // Config read mux. It sees the register values before the edge, which
    // gives read-before-write for free.
    always_comb begin
        conf_rdata = 32'h0;
        case (conf_off)
            OFF_LED:    conf_rdata = {16'h0, led_q};
            OFF_NUM:    conf_rdata = num_q;
            OFF_SWITCH: conf_rdata = {24'h0, sw_sync2_q};
`ifdef CONFREG_TIMER_EN
            OFF_TIMER:  conf_rdata = timer_q;
`endif
            default:    conf_rdata = 32'h0;
        endcase
    end

    always_comb begin
        rdata_d    = rdata_q;
        led_d      = led_q;
        num_d      = num_q;
        sw_sync1_d = switch;
        sw_sync2_d = sw_sync1_q;
`ifdef CONFREG_TIMER_EN
        timer_d    = timer_q + 32'd1;
`endif

        if (data_sram_en) begin
            rdata_d = is_conf ? conf_rdata : ram_rdata;
        end

        if (is_write && is_conf) begin
            case (conf_off)
                OFF_LED: begin
                    // LED is only 16 bits wide, so lanes 2 and 3 are dropped.
                    if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
                    if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
                end
                OFF_NUM: num_d = byte_merge(num_q, data_sram_wdata, data_sram_wen);
`ifdef CONFREG_TIMER_EN
                // A load replaces this cycle's increment.
                OFF_TIMER: timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q    <= 32'h0;
            led_q      <= 16'h0;
            num_q      <= 32'h0;
            sw_sync1_q <= 8'h0;
            sw_sync2_q <= 8'h0;
`ifdef CONFREG_TIMER_EN
            timer_q    <= 32'h0;
`endif
        end else begin
            rdata_q    <= rdata_d;
            led_q      <= led_d;
            num_q      <= num_d;
            sw_sync1_q <= sw_sync1_d;
            sw_sync2_q <= sw_sync2_d;
`ifdef CONFREG_TIMER_EN
            timer_q    <= timer_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) ram_mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;
    assign num_data        = num_q;

endmodule

// File: tb/tb_sram_confreg_resp.sv
// tb/tb_sram_confreg_resp.sv - self-checking bench for sram_confreg_resp

module tb_sram_confreg_resp;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [31:0] num_data;
    logic [7:0]  sw;

    int checks = 0;
    int errors = 0;

    sram_confreg_resp dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led),
        .num_data        (num_data),
        .switch          (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
        logic [31:0] exp_num;
    } vec_t;

    localparam int NV = 20;
    vec_t vec [NV];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request and sample the outputs just after the edge that takes it.
    task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; wen = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_timer;

    initial begin
        vec[0]  = '{1'b1, 4'hf, 32'h0000_0010, 32'hdead_beef, 1'b0, 32'h0,          16'h0000, 32'h0};
        vec[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'hdead_beef, 16'h0000, 32'h0};
        vec[2]  = '{1'b1, 4'h2, 32'h0000_0010, 32'h0000_5500, 1'b1, 32'hdead_beef, 16'h0000, 32'h0};
        vec[3]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'hdead_55ef, 16'h0000, 32'h0};
        vec[4]  = '{1'b1, 4'hf, 32'h0000_0010, 32'h1122_3344, 1'b1, 32'hdead_55ef, 16'h0000, 32'h0};
        vec[5]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'h1122_3344, 16'h0000, 32'h0};
        vec[6]  = '{1'b1, 4'hf, 32'hbfaf_f000, 32'h1234_abcd, 1'b1, 32'h0,          16'habcd, 32'h0};
        vec[7]  = '{1'b1, 4'h0, 32'hbfaf_f000, 32'h0,         1'b1, 32'h0000_abcd, 16'habcd, 32'h0};
        vec[8]  = '{1'b1, 4'he, 32'hbfaf_f000, 32'hffff_77ff, 1'b1, 32'h0000_abcd, 16'h77cd, 32'h0};
        vec[9]  = '{1'b1, 4'h0, 32'hbfaf_f000, 32'h0,         1'b1, 32'h0000_77cd, 16'h77cd, 32'h0};
        vec[10] = '{1'b1, 4'h9, 32'hbfaf_f010, 32'ha500_0042, 1'b1, 32'h0,          16'h77cd, 32'ha500_0042};
        vec[11] = '{1'b1, 4'h0, 32'hbfaf_f010, 32'h0,         1'b1, 32'ha500_0042, 16'h77cd, 32'ha500_0042};
        vec[12] = '{1'b1, 4'h0, 32'hbfaf_f020, 32'h0,         1'b1, 32'h0000_005a, 16'h77cd, 32'ha500_0042};
        vec[13] = '{1'b1, 4'hf, 32'hbfaf_f020, 32'hffff_ffff, 1'b1, 32'h0000_005a, 16'h77cd, 32'ha500_0042};
        vec[14] = '{1'b1, 4'h0, 32'hbfaf_f020, 32'h0,         1'b1, 32'h0000_005a, 16'h77cd, 32'ha500_0042};
        vec[15] = '{1'b1, 4'hf, 32'hbfaf_1234, 32'hffff_ffff, 1'b1, 32'h0,          16'h77cd, 32'ha500_0042};
        vec[16] = '{1'b1, 4'h0, 32'hbfaf_1234, 32'h0,         1'b1, 32'h0,          16'h77cd, 32'ha500_0042};
        vec[17] = '{1'b1, 4'h0, 32'h0001_0010, 32'h0,         1'b1, 32'h1122_3344, 16'h77cd, 32'ha500_0042};
        vec[18] = '{1'b0, 4'hf, 32'h0000_0010, 32'h0,         1'b1, 32'h1122_3344, 16'h77cd, 32'ha500_0042};
        vec[19] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'h1122_3344, 16'h77cd, 32'ha500_0042};

        resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; sw = 8'h5a;
        repeat (3) @(posedge clk);
        #1;
        check32("reset_rdata", rdata, 32'h0);
        check32("reset_led", {16'h0, led}, 32'h0);
        check32("reset_num", num_data, 32'h0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            req(vec[i].en, vec[i].wen, vec[i].addr, vec[i].wdata);
            if (vec[i].chk_rd) check32($sformatf("vec%0d_rdata", i), rdata, vec[i].exp_rd);
            check32($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vec[i].exp_led});
            check32($sformatf("vec%0d_num", i), num_data, vec[i].exp_num);
        end

        // rdata holds across idle cycles after a read.
        req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        check32("hold_read", rdata, 32'h1122_3344);
        for (int i = 0; i < 3; i++) begin
            req(1'b0, 4'h0, 32'hbfaf_f000, 32'h0);
            check32($sformatf("hold_idle%0d", i), rdata, 32'h1122_3344);
        end

        // Timer load, one idle cycle, then two reads across the wrap.
        req(1'b1, 4'hf, 32'hbfaf_e000, 32'hffff_fffe);
        req(1'b0, 4'h0, 32'hbfaf_e000, 32'h0);
        req(1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
`ifdef CONFREG_TIMER_EN
        exp_timer = 32'hffff_ffff;
`else
        exp_timer = 32'h0;
`endif
        check32("timer_read1", rdata, exp_timer);
        req(1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
        check32("timer_wrap", rdata, 32'h0);

        // Switch change is visible in the third read after it.
        sw = 8'hc3;
        req(1'b1, 4'h0, 32'hbfaf_f020, 32'h0);
        check32("sw_sync0", rdata, 32'h0000_005a);
        req(1'b1, 4'h0, 32'hbfaf_f020, 32'h0);
        check32("sw_sync1", rdata, 32'h0000_005a);
        req(1'b1, 4'h0, 32'hbfaf_f020, 32'h0);
        check32("sw_sync2", rdata, 32'h0000_00c3);

        // Asynchronous reset between edges; RAM survives.
        req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        check32("pre_reset_rdata", rdata, 32'h1122_3344);
        en = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check32("async_reset_led", {16'h0, led}, 32'h0);
        check32("async_reset_rdata", rdata, 32'h0);
        check32("async_reset_num", num_data, 32'h0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        check32("ram_after_reset", rdata, 32'h1122_3344);
        req(1'b1, 4'h0, 32'hbfaf_f000, 32'h0);
        check32("led_after_reset", rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
